// File: rtl/ip_tile_fsm_bitwise_shifter.sv
// Bitwise/shift IP tile: one op on two 32-bit operands per start command.
// Ports: clk, arst_n (async, active-high), csr_in/csr_in_re, data_reg_a/b, csr_out/csr_out_we, data_reg_c.
module ip_tile_fsm_bitwise_shifter #(
    parameter int CSR_IN_WIDTH  = 16,
    parameter int CSR_OUT_WIDTH = 16,
    parameter int REG_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [CSR_IN_WIDTH-1:0]  csr_in,
    output logic                     csr_in_re,
    input  logic [REG_WIDTH-1:0]     data_reg_a,
    input  logic [REG_WIDTH-1:0]     data_reg_b,
    output logic [CSR_OUT_WIDTH-1:0] csr_out,
    output logic                     csr_out_we,
    output logic [REG_WIDTH-1:0]     data_reg_c
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXEC,
        DONE,
        WAIT_CLR
    } state_t;

    state_t               state;
    logic [REG_WIDTH-1:0] op_a;
    logic [REG_WIDTH-1:0] op_b;
    logic [REG_WIDTH-1:0] work;
    logic [3:0]           op;
    logic [4:0]           cnt;

    logic                 is_shift;
    logic                 illegal;
    logic [REG_WIDTH-1:0] step;
    logic [REG_WIDTH-1:0] logic_res;
    logic [REG_WIDTH-1:0] fin_res;

    // Reserved command bits are intentionally ignored.
    logic unused_rsvd;
    assign unused_rsvd = ^{csr_in[14:12], csr_in[7:5]};

    assign is_shift = (op >= 4'd4) && (op <= 4'd8);

    // One-bit move of the working register for the latched shift op.
    always_comb begin
        step = work;
        unique case (op)
            4'd4:    step = {work[30:0], 1'b0};
            4'd5:    step = {1'b0, work[31:1]};
            4'd6:    step = {work[31], work[31:1]};
            4'd7:    step = {work[30:0], work[31]};
            4'd8:    step = {work[0], work[31:1]};
            default: step = work;
        endcase
    end

    always_comb begin
        logic_res = '0;
        illegal   = 1'b0;
        unique case (op)
            4'd0:    logic_res = op_a & op_b;
            4'd1:    logic_res = op_a | op_b;
            4'd2:    logic_res = op_a ^ op_b;
            4'd3:    logic_res = ~op_a;
            4'd4, 4'd5, 4'd6, 4'd7, 4'd8:
                     logic_res = '0;
            default: illegal   = 1'b1;
        endcase
    end

    // cnt==0 only happens for sh=0: the single EXEC cycle leaves A as is.
    assign fin_res = is_shift ? ((cnt == 5'd0) ? work : step) : logic_res;

    // arst_n is active-high despite its name.
    always_ff @(posedge clk or posedge arst_n) begin
        if (arst_n) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            work       <= '0;
            op         <= '0;
            cnt        <= '0;
            csr_in_re  <= 1'b0;
            csr_out_we <= 1'b0;
            csr_out    <= '0;
            data_reg_c <= '0;
        end else begin
            csr_in_re  <= 1'b0;
            csr_out_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Latch everything here so the LOAD-cycle pulses
                    // coincide with the consumed command.
                    if (csr_in[15]) begin
                        state      <= LOAD;
                        csr_in_re  <= 1'b1;
                        csr_out_we <= 1'b1;
                        op_a       <= data_reg_a;
                        op_b       <= data_reg_b;
                        work       <= data_reg_a;
                        op         <= csr_in[11:8];
                        cnt        <= csr_in[4:0];
                        csr_out    <= {8'h00, csr_in[11:8], 4'b0010};
                    end
                end
                LOAD: begin
                    state <= EXEC;
                end
                EXEC: begin
                    if (is_shift && (cnt > 5'd1)) begin
                        work <= step;
                        cnt  <= cnt - 5'd1;
                    end else begin
                        work       <= fin_res;
                        cnt        <= '0;
                        data_reg_c <= fin_res;
                        csr_out    <= {8'h00, op, 1'b0, illegal,
                                       1'b0, 1'b1};
                        csr_out_we <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    if (!csr_in[15]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_tile_fsm_bitwise_shifter.sv
// Bench for ip_tile_fsm_bitwise_shifter: random and directed commands,
// queue scoreboard with an arithmetic reference model.
module tb_ip_tile_fsm_bitwise_shifter;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [15:0] csr_in;
    logic        csr_in_re;
    logic [31:0] data_reg_a;
    logic [31:0] data_reg_b;
    logic [15:0] csr_out;
    logic        csr_out_we;
    logic [31:0] data_reg_c;

    ip_tile_fsm_bitwise_shifter dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .csr_in     (csr_in),
        .csr_in_re  (csr_in_re),
        .data_reg_a (data_reg_a),
        .data_reg_b (data_reg_b),
        .csr_out    (csr_out),
        .csr_out_we (csr_out_we),
        .data_reg_c (data_reg_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] c;
        logic [15:0] st;
        int          n;
    } exp_t;

    exp_t q[$];
    int   vectors  = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   re_cnt   = 0;
    int   we_cnt   = 0;
    int   done_cnt = 0;
    int   re_cyc   = 0;
    logic prev_re  = 1'b0;
    logic prev_we  = 1'b0;
    logic in_fl    = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(logic [31:0] a, logic [31:0] b,
                                   logic [15:0] cmd);
        exp_t               e;
        logic [3:0]         op;
        int                 sh;
        logic [63:0]        dbl;
        logic signed [31:0] sa;
        logic               err;
        op  = cmd[11:8];
        sh  = int'(cmd[4:0]);
        dbl = {a, a} << sh;
        sa  = a;
        err = 1'b0;
        e.n = 1;
        case (op)
            4'd0: e.c = a & b;
            4'd1: e.c = a | b;
            4'd2: e.c = a ^ b;
            4'd3: e.c = ~a;
            4'd4: e.c = a << sh;
            4'd5: e.c = a >> sh;
            4'd6: e.c = sa >>> sh;
            4'd7: e.c = dbl[63:32];
            4'd8: begin
                dbl = {a, a} >> sh;
                e.c = dbl[31:0];
            end
            default: begin
                e.c = 32'h0;
                err = 1'b1;
            end
        endcase
        if (op >= 4 && op <= 8 && sh > 0) e.n = sh;
        e.st = {8'h00, op, 1'b0, err, 1'b0, 1'b1};
        return e;
    endfunction

    // Monitor: pops the scoreboard on every completion pulse.
    always @(negedge clk) begin : mon
        exp_t e;
        if (arst_n) begin
            prev_re = 1'b0;
            prev_we = 1'b0;
            in_fl   = 1'b0;
        end else begin
            if (csr_in_re) begin
                re_cnt++;
                re_cyc = cyc;
                check("re_single", {31'h0, prev_re}, 32'h0);
            end
            if (csr_out_we) begin
                we_cnt++;
                check("we_single", {31'h0, prev_we}, 32'h0);
                if (q.size() == 0) begin
                    check("unexpected_we", 32'h1, 32'h0);
                end else if (!csr_out[0]) begin
                    check("busy_status", {16'h0, csr_out},
                          {16'h0, 8'h00, q[0].st[7:4], 4'b0010});
                    in_fl = 1'b1;
                end else begin
                    e = q.pop_front();
                    check("result", data_reg_c, e.c);
                    check("status", {16'h0, csr_out}, {16'h0, e.st});
                    check("latency", cyc - re_cyc, 1 + e.n);
                    in_fl = 1'b0;
                    done_cnt++;
                end
            end else if (in_fl) begin
                check("busy_hold", {29'h0, csr_out[2:0]}, 32'h2);
            end
            prev_re = csr_in_re;
            prev_we = csr_out_we;
        end
    end

    task automatic wait_re(input int r0);
        for (int i = 0; i < 10 && re_cnt == r0; i++) @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [31:0] b,
                           input logic [15:0] cmd, input int hold);
        int r0, w0, d0;
        @(posedge clk);
        #1;
        r0 = re_cnt;
        w0 = we_cnt;
        d0 = done_cnt;
        data_reg_a = a;
        data_reg_b = b;
        csr_in     = cmd | 16'h8000;
        q.push_back(model(a, b, cmd));
        wait_re(r0);
        // Late operand/command churn must not disturb the running op.
        data_reg_a = $urandom;
        data_reg_b = $urandom;
        csr_in     = 16'h8000 | 16'($urandom_range(0, 16'h7fff));
        for (int i = 0; i < 80 && done_cnt == d0; i++) @(posedge clk);
        if (done_cnt == d0) begin
            check("done_timeout", 32'h1, 32'h0);
            q.delete();
        end
        repeat (hold) @(posedge clk);
        #1;
        csr_in = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("re_count", re_cnt - r0, 1);
        check("we_count", we_cnt - w0, 2);
    endtask

    task automatic reset_mid_op();
        int r0;
        @(posedge clk);
        #1;
        r0 = re_cnt;
        data_reg_a = 32'hFFFF0001;
        data_reg_b = 32'h0;
        csr_in     = 16'h841F;
        q.push_back(model(32'hFFFF0001, 32'h0, 16'h841F));
        wait_re(r0);
        repeat (5) @(posedge clk);
        #1;
        arst_n = 1'b1;
        #1;
        check("rst_c", data_reg_c, 32'h0);
        check("rst_csr", {16'h0, csr_out}, 32'h0);
        check("rst_re", {31'h0, csr_in_re}, 32'h0);
        check("rst_we", {31'h0, csr_out_we}, 32'h0);
        q.delete();
        csr_in = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        arst_n = 1'b0;
        r0 = re_cnt;
        repeat (6) @(posedge clk);
        #1;
        check("idle_no_re", re_cnt - r0, 0);
        check("idle_csr", {16'h0, csr_out}, 32'h0);
    endtask

    initial begin
        logic [15:0] cmd;
        arst_n     = 1'b1;
        csr_in     = 16'h0;
        data_reg_a = 32'h0;
        data_reg_b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("init_c", data_reg_c, 32'h0);
        check("init_csr", {16'h0, csr_out}, 32'h0);
        check("init_re", {31'h0, csr_in_re}, 32'h0);
        check("init_we", {31'h0, csr_out_we}, 32'h0);
        arst_n = 1'b0;

        run_cmd(32'hA5A5A5A5, 32'h12A2A3A5, 16'h81F5, 20);
        check("or_val", data_reg_c, 32'hB7A7A7A5);
        run_cmd(32'hA5A5A5A5, 32'h0, 16'h8404, 0);
        check("sll_val", data_reg_c, 32'h5A5A5A50);
        run_cmd(32'h80000000, 32'h0, 16'h861F, 1);
        check("sra_val", data_reg_c, 32'hFFFFFFFF);
        run_cmd(32'h80000000, 32'h0, 16'h851F, 0);
        check("srl_val", data_reg_c, 32'h00000001);
        run_cmd(32'hA5A5A5A5, 32'h0, 16'h8801, 2);
        check("ror_val", data_reg_c, 32'hD2D2D2D2);
        run_cmd(32'hA5A5A5A5, 32'h0, 16'h8700, 0);
        check("rol0_val", data_reg_c, 32'hA5A5A5A5);
        run_cmd(32'h12345678, 32'h9ABCDEF0, 16'h8F00, 0);
        check("ill_csr", {16'h0, csr_out}, 32'h00F5);

        reset_mid_op();
        run_cmd(32'h0F0F0000, 32'h00000F0F, 16'h8100, 0);
        check("post_rst", data_reg_c, 32'h0F0F0F0F);

        for (int i = 0; i < 60; i++) begin
            cmd = 16'($urandom);
            if (i % 4 != 0) cmd[11:8] = 4'($urandom_range(0, 8));
            run_cmd($urandom, $urandom, cmd, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
